// File: rtl/div_32_pkg.sv
// div_32_pkg: shared encodings and constants for the multi-cycle divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_32_pkg;

  // funct3[1:0] of the RV32M divide group
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int DIV_ITER    = 32;
  localparam int DIV_LATENCY = 34;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/cla_32.sv
// cla_32: 32-bit adder/subtractor, 4-bit blocks with lookahead across blocks.
// Latency: combinational.
// Backpressure: none.
// Ports: src1, src2 operands; sub_flag=1 computes src1 - src2 (carry_out=1
// means no borrow); sum is the low 32 bits.
module cla_32 (
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        sub_flag,
  output logic [31:0] sum,
  output logic        carry_out
);

  logic [31:0] b;
  logic [31:0] g;
  logic [31:0] p;

  assign b = src2 ^ {32{sub_flag}};
  assign g = src1 & b;
  assign p = src1 ^ b;

  always_comb begin
    logic [7:0] grp_g;
    logic [7:0] grp_p;
    logic [8:0] grp_c;
    logic       acc;
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    acc   = 1'b0;
    sum   = '0;
    for (int k = 0; k < 8; k++) begin
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = &p[4*k +: 4];
    end
    // Block carry-ins are each a flat function of the block G/P terms.
    for (int k = 0; k <= 8; k++) begin
      acc = sub_flag;
      for (int j = 0; j < k; j++) begin
        acc = grp_g[j] | (grp_p[j] & acc);
      end
      grp_c[k] = acc;
    end
    for (int k = 0; k < 8; k++) begin
      acc = grp_c[k];
      for (int i = 0; i < 4; i++) begin
        sum[4*k+i] = p[4*k+i] ^ acc;
        acc        = g[4*k+i] | (p[4*k+i] & acc);
      end
    end
    carry_out = grp_c[8];
  end

endmodule

// File: rtl/div_32.sv
// div_32: RV32M DIV/DIVU/REM/REMU, restoring division, one quotient bit/cycle.
// Latency: fixed 34 cycles from accepted start to the done pulse.
// Backpressure: start is ignored while busy; accepted again in the done cycle.
// Ports: clk, rst (async, active high); start/op/src1/src2 request;
// busy while in flight, done one-cycle pulse, result held until next start.
module div_32
  import div_32_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = DIV_ITER
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  logic [1:0]      state_q, state_d;
  logic [1:0]      op_q;
  logic            sgn1_q, sgn2_q, dvs_zero_q;
  logic [XLEN-1:0] quo_q;     // dividend, shifts left and fills with quotient bits
  logic [XLEN-1:0] dvs_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] result_q;
  logic [5:0]      cnt_q;

  logic            accept, op_signed, calc_last, trial_ok, op_rem_q, neg_res;
  logic [XLEN-1:0] shifted, fix_val;
  logic [XLEN-1:0] add1_a, add1_b, add1_sum, add2_b, add2_sum;
  logic            add1_co, add2_co;

  assign accept    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign op_signed = op_is_signed(op);
  assign calc_last = (cnt_q == 6'(ITER - 1));

  // Low 32 bits of {rem, dividend msb}; the dropped bit 32 is rem_q msb.
  assign shifted  = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
  assign trial_ok = rem_q[XLEN-1] | add1_co;

  assign op_rem_q = op_is_rem(op_q);
  assign fix_val  = op_rem_q ? rem_q : quo_q;
  // A zero divisor yields all-ones quotient regardless of signs.
  assign neg_res  = op_rem_q ? sgn1_q : ((sgn1_q ^ sgn2_q) & ~dvs_zero_q);

  // The trial adder is idle outside CALC, so at accept it forms 0 - src1.
  assign add1_a = (state_q == ST_CALC) ? shifted : '0;
  assign add1_b = (state_q == ST_CALC) ? dvs_q : src1;
  // Second adder: 0 - src2 at accept (carry_out flags src2 == 0),
  // 0 - quotient/remainder in FIX.
  assign add2_b = (state_q == ST_FIX) ? fix_val : src2;

  cla_32 u_cla_trial (
    .src1      (add1_a),
    .src2      (add1_b),
    .sub_flag  (1'b1),
    .sum       (add1_sum),
    .carry_out (add1_co)
  );

  cla_32 u_cla_neg (
    .src1      ('0),
    .src2      (add2_b),
    .sub_flag  (1'b1),
    .sum       (add2_sum),
    .carry_out (add2_co)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_CALC;
      ST_CALC: if (calc_last) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_CALC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      sgn1_q     <= 1'b0;
      sgn2_q     <= 1'b0;
      dvs_zero_q <= 1'b0;
      quo_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q       <= op;
        sgn1_q     <= op_signed & src1[XLEN-1];
        sgn2_q     <= op_signed & src2[XLEN-1];
        quo_q      <= (op_signed && src1[XLEN-1]) ? add1_sum : src1;
        dvs_q      <= (op_signed && src2[XLEN-1]) ? add2_sum : src2;
        dvs_zero_q <= add2_co;
        rem_q      <= '0;
        cnt_q      <= '0;
      end else if (state_q == ST_CALC) begin
        rem_q <= trial_ok ? add1_sum : shifted;
        quo_q <= {quo_q[XLEN-2:0], trial_ok};
        cnt_q <= cnt_q + 6'd1;
      end else if (state_q == ST_FIX) begin
        result_q <= neg_res ? add2_sum : fix_val;
      end
    end
  end

  assign busy   = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule
